fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch (IF) stage plus IF/ID pipeline register; feeds the decode stage of the 5-stage datapath (IF/ID/EX/MEM/WB).
- Holds the word-addressed PC and drives a synchronous-read instruction memory.
- Gated by `start`; handles hazard stalls, EX-stage jump redirects and pipeline flushes.
- Delivers pc, pc+1, instruction and valid to ID.

Parameters:
- RESET_PC, 32'h0000_0000, first PC fetched after start; PC value held while idle.
- ADDR_W, 10, instruction-memory word-address width; `imem_addr` is `pc_next[ADDR_W-1:0]`.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin fetching; sampled in IDLE only.
- stall  in  1  hazard stall; freeze PC and IF/ID.
- flush  in  1  load a bubble into IF/ID.
- redirect  in  1  jump/branch taken in EX.
- redirect_pc  in  32  jump target, word address.
- imem_addr  out  ADDR_W  instruction-memory read address.
- imem_rdata  in  32  instruction data; valid 1 cycle after its address.
- pc_id  out  32  IF/ID: pc of the instruction.
- pc_plus1_id  out  32  IF/ID: pc+1.
- instr_id  out  32  IF/ID: instruction word.
- valid_id  out  1  IF/ID: slot holds a real instruction.
- running  out  1  high in RUN.
- fetch_count  out  32  count of valid IF/ID loads (optional feature).

Behaviour:
- Reset (asynchronous, any time, including mid-run):
  - state = IDLE, pc_q = RESET_PC.
  - pc_id, pc_plus1_id, instr_id, valid_id, running and fetch_count all = 0.
- States: IDLE, RUN.
  - IDLE -> RUN when start=1.
  - RUN is terminal until rst.
  - start while in RUN is ignored.
- pc_next, combinational, priority order:
  - IDLE: RESET_PC.
  - RUN and redirect: redirect_pc.
  - RUN and stall: pc_q.
  - Otherwise: pc_q + 1.
- Memory addressing:
  - imem_addr = pc_next[ADDR_W-1:0], so imem_rdata is aligned with pc_q the following cycle.
  - The first RUN cycle therefore sees mem[RESET_PC] with no priming cycle.
- IF/ID update in RUN, priority order:
  - redirect or flush: valid_id <= 0, instr_id <= 0 (NOP), pc fields <= 0; pc_q <= pc_next.
  - stall: IF/ID and pc_q hold.
  - Otherwise: pc_id <= pc_q, pc_plus1_id <= pc_q + 1, instr_id <= imem_rdata, valid_id <= 1; pc_q <= pc_q + 1.
- In IDLE, IF/ID holds its bubble (valid_id = 0).
- Simultaneous events:
  - redirect+stall: redirect wins; the PC loads the target and IF/ID becomes a bubble (EX is older than the stalled ID instruction).
  - flush+stall: the flush bubble wins, but the PC holds because redirect=0.
- Arithmetic:
  - PC is 32-bit, wraps modulo 2^32 (32'hFFFF_FFFF + 1 = 0).
  - Address bits above ADDR_W are ignored by the memory.
- Latency: an instruction appears on instr_id 2 cycles after its address is driven on imem_addr.

Optional Feature:
- Macro: FETCH_COUNT_EN.
- Defined: fetch_count increments by 1 on every IF/ID load with valid_id <= 1. It wraps at 2^32 and is cleared only by rst.
- Undefined: no counter register is built and fetch_count is tied to 0.

Decomposition:
- Shared package fetch_pkg:
  - typedef enum logic {IDLE, RUN} fetch_state_t.
  - NOP_INSTR = 32'h0.
  - PC_W = 32.
- One sub-module: if_id_reg.
  - Holds the IF/ID register fields with load/hold/bubble controls and asynchronous reset.
  - Instantiated once by fetch_stage.

Test Plan:
- Reset, then start pulse at cycle 3 with RESET_PC = 0 and mem[i] = 32'hA000_0000 + i:
  - imem_addr is 0,1,2,…
  - valid_id first rises at cycle 5 with pc_id = 0, instr_id = 32'hA000_0000, pc_plus1_id = 1.
- Stall held 2 cycles while pc_id = 4:
  - pc_id, instr_id and imem_addr = 4+1 hold for both cycles.
  - Fetch resumes with pc_id = 5.
- Redirect with redirect_pc = 32'h40 while pc_q = 7:
  - The next IF/ID is a bubble (valid_id = 0, instr_id = 0).
  - The following slot has pc_id = 32'h40, instr_id = mem[32'h40].
- Redirect and stall asserted together: behaviour identical to the previous redirect case; the PC is not frozen.
- rst asserted asynchronously mid-RUN between clock edges:
  - Outputs go to 0 immediately, state = IDLE.
  - A later start restarts fetching from RESET_PC.
- FETCH_COUNT_EN defined, 10 valid fetches including 1 flush and 2 stall cycles: fetch_count = 10.
- FETCH_COUNT_EN undefined: fetch_count stays 0.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch stage.
// Provides fetch_state_t, the IF/ID bundle if_id_t, NOP_INSTR and PC_W.
package fetch_pkg;

  localparam int PC_W = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0;

  typedef enum logic {
    IDLE,
    RUN
  } fetch_state_t;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] pc_plus1;
    logic [31:0]     instr;
    logic            valid;
  } if_id_t;

  function automatic logic [PC_W-1:0] pc_inc(
    input logic [PC_W-1:0] pc
  );
    return pc + 32'd1;
  endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// if_id_reg: IF/ID pipeline register with bubble > load > hold priority.
// Ports: clk, rst (async high), load, bubble, d (next bundle), q (held bundle).
module if_id_reg
  import fetch_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   load,
  input  logic   bubble,
  input  if_id_t d,
  output if_id_t q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (bubble) begin
      q.pc       <= '0;
      q.pc_plus1 <= '0;
      q.instr    <= NOP_INSTR;
      q.valid    <= 1'b0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: IF stage with PC, sync-read imem addressing and IF/ID register.
// Ports: clk, rst, start, stall, flush, redirect, redirect_pc, imem_addr,
//   imem_rdata, pc_id, pc_plus1_id, instr_id, valid_id, running, fetch_count.
// Optional: define FETCH_COUNT_EN to build the valid-load counter.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000,
  parameter int              ADDR_W   = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stall,
  input  logic              flush,
  input  logic              redirect,
  input  logic [PC_W-1:0]   redirect_pc,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  output logic [PC_W-1:0]   pc_id,
  output logic [PC_W-1:0]   pc_plus1_id,
  output logic [31:0]       instr_id,
  output logic              valid_id,
  output logic              running,
  output logic [31:0]       fetch_count
);

  fetch_state_t    state;
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_inc_q;
  logic [PC_W-1:0] pc_next;
  logic            run;
  logic            kill;
  logic            load;
  if_id_t          d;
  if_id_t          q;

  assign run      = (state == RUN);
  assign kill     = run & (redirect | flush);
  assign load     = run & ~(stall | redirect | flush);
  assign pc_inc_q = pc_inc(pc_q);

  // pc_q always follows pc_next, so the address presented to the
  // memory this cycle is the pc whose data arrives next cycle.
  always_comb begin
    pc_next = pc_inc_q;
    unique case (1'b1)
      !run:
        pc_next = RESET_PC;
      run && redirect:
        pc_next = redirect_pc;
      run && !redirect && stall:
        pc_next = pc_q;
      run && !redirect && !stall:
        pc_next = pc_inc_q;
    endcase
  end

  assign imem_addr = pc_next[ADDR_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      running <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state   <= RUN;
            running <= 1'b1;
          end
        end
        RUN: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_next;
    end
  end

  always_comb begin
    d          = '0;
    d.pc       = pc_q;
    d.pc_plus1 = pc_inc_q;
    d.instr    = imem_rdata;
    d.valid    = 1'b1;
  end

  if_id_reg u_if_id (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .bubble (kill),
    .d      (d),
    .q      (q)
  );

  assign pc_id       = q.pc;
  assign pc_plus1_id = q.pc_plus1;
  assign instr_id    = q.instr;
  assign valid_id    = q.valid;

`ifdef FETCH_COUNT_EN
  logic [31:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

  assign fetch_count = cnt_q;
`else
  assign fetch_count = '0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed stimulus with a queue scoreboard for IF/ID loads.
// Ports: none.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic [9:0]  imem_addr;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] pc_id;
  logic [31:0] pc_plus1_id;
  logic [31:0] instr_id;
  logic        valid_id;
  logic        running;
  logic [31:0] fetch_count;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc1;
    logic [31:0] ins;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   n_loads = 0;
  logic stall_prev = 1'b0;

  fetch_stage #(
    .RESET_PC (32'h0),
    .ADDR_W   (10)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .stall       (stall),
    .flush       (flush),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .pc_id       (pc_id),
    .pc_plus1_id (pc_plus1_id),
    .instr_id    (instr_id),
    .valid_id    (valid_id),
    .running     (running),
    .fetch_count (fetch_count)
  );

  always #5 clk = ~clk;

  // mem[i] = A000_0000 + i, one-cycle synchronous read
  always @(posedge clk)
    imem_rdata <= 32'hA000_0000 + {22'd0, imem_addr};

  always @(posedge clk)
    stall_prev <= stall;

  task automatic chk(
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // A fresh load is any valid slot not held over by a stall
  always @(negedge clk) begin
    if (!rst && valid_id && !stall_prev) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_load got=%h want=none", pc_id);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("pc_id", pc_id, e.pc);
        chk("pc_plus1_id", pc_plus1_id, e.pc1);
        chk("instr_id", instr_id, e.ins);
      end
    end
  end

  task automatic push(input logic [31:0] p, input logic [31:0] p1,
                      input logic [31:0] ins);
    exp_t e;
    e.pc  = p;
    e.pc1 = p1;
    e.ins = ins;
    q.push_back(e);
    n_loads++;
  endtask

  task automatic cyc(
    input logic        st,
    input logic        sl,
    input logic        fl,
    input logic        rd,
    input logic [31:0] rpc,
    input logic [9:0]  exp_addr
  );
    start       = st;
    stall       = sl;
    flush       = fl;
    redirect    = rd;
    redirect_pc = rpc;
    #1;
    chk("imem_addr", 32'(imem_addr), 32'(exp_addr));
    @(negedge clk);
  endtask

  task automatic bubble_chk();
    chk("bubble_valid", 32'(valid_id), 32'd0);
    chk("bubble_instr", instr_id, 32'h0);
    chk("bubble_pc", pc_id, 32'h0);
  endtask

  task automatic reset_chk();
    chk("rst_valid", 32'(valid_id), 32'd0);
    chk("rst_pc_id", pc_id, 32'h0);
    chk("rst_pc1", pc_plus1_id, 32'h0);
    chk("rst_instr", instr_id, 32'h0);
    chk("rst_running", 32'(running), 32'd0);
    chk("rst_count", fetch_count, 32'h0);
    chk("rst_addr", 32'(imem_addr), 32'h0);
  endtask

  task automatic count_chk(input logic [31:0] n);
`ifdef FETCH_COUNT_EN
    chk("fetch_count", fetch_count, n);
`else
    chk("fetch_count", fetch_count, 32'h0 & n);
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    reset_chk();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    cyc(0, 0, 0, 0, 0, 10'd0);
    cyc(0, 0, 0, 0, 0, 10'd0);
    chk("idle_running", 32'(running), 32'd0);
    cyc(1, 0, 0, 0, 0, 10'd0);
    chk("run_running", 32'(running), 32'd1);
    push(32'h0, 32'h1, 32'hA000_0000);
    cyc(0, 0, 0, 0, 0, 10'd1);
    push(32'h1, 32'h2, 32'hA000_0001);
    cyc(0, 0, 0, 0, 0, 10'd2);
    push(32'h2, 32'h3, 32'hA000_0002);
    cyc(0, 0, 0, 0, 0, 10'd3);
    push(32'h3, 32'h4, 32'hA000_0003);
    cyc(0, 0, 0, 0, 0, 10'd4);
    push(32'h4, 32'h5, 32'hA000_0004);
    cyc(0, 0, 0, 0, 0, 10'd5);
    // two stall cycles while pc_id = 4
    cyc(0, 1, 0, 0, 0, 10'd5);
    chk("stall1_pc", pc_id, 32'h4);
    chk("stall1_instr", instr_id, 32'hA000_0004);
    cyc(0, 1, 0, 0, 0, 10'd5);
    chk("stall2_pc", pc_id, 32'h4);
    chk("stall2_valid", 32'(valid_id), 32'd1);
    push(32'h5, 32'h6, 32'hA000_0005);
    cyc(0, 0, 0, 0, 0, 10'd6);
    push(32'h6, 32'h7, 32'hA000_0006);
    cyc(0, 0, 0, 0, 0, 10'd7);
    // redirect to 0x40 while pc_q = 7
    cyc(0, 0, 0, 1, 32'h40, 10'h40);
    bubble_chk();
    push(32'h40, 32'h41, 32'hA000_0040);
    cyc(0, 0, 0, 0, 0, 10'h41);
    push(32'h41, 32'h42, 32'hA000_0041);
    cyc(0, 0, 0, 0, 0, 10'h42);
    // redirect together with stall: pc must not freeze
    cyc(0, 1, 0, 1, 32'h80, 10'h80);
    bubble_chk();
    push(32'h80, 32'h81, 32'hA000_0080);
    cyc(0, 0, 0, 0, 0, 10'h81);
    // flush alone drops pc 0x81 and advances
    cyc(0, 0, 1, 0, 0, 10'h82);
    bubble_chk();
    push(32'h82, 32'h83, 32'hA000_0082);
    cyc(0, 0, 0, 0, 0, 10'h83);
    // flush + stall: bubble, pc holds
    cyc(0, 1, 1, 0, 0, 10'h83);
    bubble_chk();
    push(32'h83, 32'h84, 32'hA000_0083);
    cyc(0, 0, 0, 0, 0, 10'h84);
    // start while running is ignored
    push(32'h84, 32'h85, 32'hA000_0084);
    cyc(1, 0, 0, 0, 0, 10'h85);
    // PC wrap and upper address bits ignored
    cyc(0, 0, 0, 1, 32'hFFFF_FFFF, 10'h3FF);
    bubble_chk();
    push(32'hFFFF_FFFF, 32'h0, 32'hA000_03FF);
    cyc(0, 0, 0, 0, 0, 10'h0);
    push(32'h0, 32'h1, 32'hA000_0000);
    cyc(0, 0, 0, 0, 0, 10'h1);
    count_chk(32'd15);
    // asynchronous reset between edges
    #2;
    rst = 1'b1;
    #1;
    reset_chk();
    n_loads = 0;
    @(negedge clk);
    rst = 1'b0;
    cyc(0, 0, 0, 0, 0, 10'd0);
    cyc(1, 0, 0, 0, 0, 10'd0);
    push(32'h0, 32'h1, 32'hA000_0000);
    cyc(0, 0, 0, 0, 0, 10'd1);
    push(32'h1, 32'h2, 32'hA000_0001);
    cyc(0, 0, 0, 0, 0, 10'd2);
    push(32'h2, 32'h3, 32'hA000_0002);
    cyc(0, 0, 0, 0, 0, 10'd3);
    cyc(0, 1, 0, 0, 0, 10'd3);
    cyc(0, 1, 0, 0, 0, 10'd3);
    chk("queue_empty", 32'(q.size()), 32'd0);
    count_chk(32'd3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
